data_mem_resp: RTL and testbench

- Data-memory responder: the memory-side end of the core's data-memory interface (chip_select_d, write_enable_d, read_enable_d, address, data_to_m, data_m).
- Accepts one byte, halfword or word load/store at a time and adds a configurable number of wait states.
- Signals completion with a one-cycle ready pulse; flags misaligned and out-of-range accesses.
- Sits between the core's control/LSU path and a word-organised little-endian RAM array.

---
 rtl/data_mem_resp.sv | 164 ++++++++++++++++
 tb/tb_data_mem_resp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Memory-side responder for the core's data port: byte/halfword/word access to a
// little-endian word RAM with a fixed number of wait states and a one-cycle ready pulse.
//
//   state  | meaning
//   IDLE   | waiting for a request; captures the access descriptor when one arrives
//   WAIT   | counting down wait states before the access
//   RESP   | access committed on entry; ready (and err) asserted for this cycle only
module data_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chip_select_d,
  input  logic        write_enable_d,
  input  logic        read_enable_d,
  input  logic [31:0] address,
  input  logic [1:0]  size,
  input  logic [31:0] data_to_m,
  output logic [31:0] data_m,
  output logic        ready,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic [31:0] data_m_q;
  logic        err_q;

  logic        req, accept, commit, bypass;
  logic [31:0] acc_addr, acc_wdata;
  logic [1:0]  acc_size, lane;
  logic        acc_wr, acc_err, in_range, mem_we;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane, rword, rshift, rdata;

  logic [31:0] mem_q [DEPTH_WORDS];

  assign req    = chip_select_d & (write_enable_d | read_enable_d);
  assign accept = (state_q == S_IDLE) & req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access commits on the acceptance edge, so it uses the live inputs.
  assign bypass    = (state_q == S_IDLE);
  assign acc_addr  = bypass ? address        : addr_q;
  assign acc_size  = bypass ? size           : size_q;
  assign acc_wdata = bypass ? data_to_m      : wdata_q;
  assign acc_wr    = bypass ? write_enable_d : wr_q;

  assign in_range = (acc_addr[31:2] < 30'(DEPTH_WORDS));
  assign acc_err  = (acc_size == 2'b11)
                  | ((acc_size == 2'b01) & acc_addr[0])
                  | ((acc_size == 2'b10) & (acc_addr[1:0] != 2'b00))
                  | ~in_range;
  assign idx  = acc_addr[AW+1:2];
  assign lane = acc_addr[1:0];

  always_comb begin
    be    = 4'b0000;
    wlane = acc_wdata;
    rdata = 32'd0;
    case (acc_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{acc_wdata[7:0]}};
        rdata = {24'd0, rshift[7:0]};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{acc_wdata[15:0]}};
        rdata = {16'd0, rshift[15:0]};
      end
      2'b10: begin
        be    = 4'b1111;
        rdata = rword;
      end
      default: begin
        be    = 4'b0000;
        rdata = 32'd0;
      end
    endcase
  end

  assign rword  = mem_q[idx];
  assign rshift = rword >> {lane, 3'b000};
  assign mem_we = commit & acc_wr & ~acc_err & ~rst;

  // RAM is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      size_q   <= 2'b00;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
      data_m_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address;
        size_q  <= size;
        wdata_q <= data_to_m;
        wr_q    <= write_enable_d;
      end
      err_q <= commit & acc_err;
      if (commit) begin
        if (acc_err)      data_m_q <= 32'd0;
        else if (!acc_wr) data_m_q <= rdata;
      end
    end
  end

  assign ready  = (state_q == S_RESP);
  assign err    = err_q;
  assign data_m = data_m_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized bench for data_mem_resp: three instances (0, 1 and 3 wait states) checked
// against a byte-array memory model, plus directed lane, error, reset and throughput cases.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cs;
  logic        we_i, re_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic [31:0] dm [3];
  logic        rdy [3];
  logic        erro [3];

  int tests = 0;
  int fails = 0;

  logic [7:0]  mref [3][4096];
  logic [31:0] dmod [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_resp #(
      .DEPTH_WORDS(1024),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .chip_select_d (cs[g]),
      .write_enable_d(we_i),
      .read_enable_d (re_i),
      .address       (addr_i),
      .size          (size_i),
      .data_to_m     (wdata_i),
      .data_m        (dm[g]),
      .ready         (rdy[g]),
      .err           (erro[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request to instance d, checked against the byte model (latency, err, data_m).
  task automatic txn(input int d, input bit we, input bit re, input logic [31:0] a,
                     input logic [1:0] sz, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    int lat;
    bit err_idle;
    bit exp_e;
    logic [31:0] exp_d;
    int base;
    @(negedge clk);
    cs = 3'b000;
    cs[d] = 1'b1;
    we_i = we; re_i = re; addr_i = a; size_i = sz; wdata_i = wd;
    @(posedge clk);
    #1 cs = 3'b000;
    lat = 0;
    err_idle = 1'b0;
    @(negedge clk);
    while (!rdy[d] && lat < 40) begin
      if (erro[d]) err_idle = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = dm[d];
    er = erro[d];

    exp_e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
            || (a >= 32'd4096);
    exp_d = dmod[d];
    base  = int'(a[11:0]);
    if (exp_e) begin
      dmod[d] = 32'd0;
      exp_d   = 32'd0;
    end else if (we) begin
      for (int k = 0; k < (1 << sz); k++) mref[d][base + k] = wd[8*k +: 8];
    end else begin
      exp_d = 32'd0;
      for (int k = 0; k < (1 << sz); k++) exp_d[8*k +: 8] = mref[d][base + k];
      dmod[d] = exp_d;
    end

    chk($sformatf("lat d%0d a%08h", d, a), lat, ws_of(d));
    chk($sformatf("err d%0d a%08h sz%0d", d, a, sz), {31'd0, er}, {31'd0, exp_e});
    if (!(we && exp_e)) chk($sformatf("data d%0d a%08h sz%0d", d, a, sz), rd, exp_d);
    chk($sformatf("err_idle d%0d", d), {31'd0, err_idle}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    bit saw;
    logic [31:0] a;
    logic [1:0] sz;
    int op, d, r;

    for (int i = 0; i < 3; i++) begin
      dmod[i] = 32'd0;
      for (int j = 0; j < 4096; j++) mref[i][j] = 8'h00;
    end

    rst = 1'b1;
    cs = 3'b000; we_i = 1'b0; re_i = 1'b0; addr_i = 32'd0; size_i = 2'b00; wdata_i = 32'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", {31'd0, rdy[i]}, 32'd0);
      chk("rst_err", {31'd0, erro[i]}, 32'd0);
      chk("rst_data", dm[i], 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 128; w += 4) txn(i, 1'b1, 1'b0, 32'(w), 2'b10, 32'd0, rd, er);
      txn(i, 1'b1, 1'b0, 32'h0000_0FFC, 2'b10, 32'd0, rd, er);
    end

    // Reset two cycles into a 3-wait-state store aborts it.
    @(negedge clk);
    cs = 3'b100; we_i = 1'b1; re_i = 1'b0; addr_i = 32'h10; size_i = 2'b10; wdata_i = 32'hDEADBEEF;
    @(posedge clk);
    #1 cs = 3'b000;
    saw = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy[2]) saw = 1'b1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rdy[2]) saw = 1'b1;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rdy[2]) saw = 1'b1;
    end
    chk("rst_abort_ready", {31'd0, saw}, 32'd0);
    for (int i = 0; i < 3; i++) dmod[i] = 32'd0;
    chk("rst_data_cleared", dm[2], 32'd0);
    txn(2, 1'b0, 1'b1, 32'h10, 2'b10, 32'd0, rd, er);
    chk("rst_abort_load", rd, 32'h0000_0000);

    // Lane behaviour with one wait state.
    txn(1, 1'b1, 1'b0, 32'h20, 2'b10, 32'h11223344, rd, er);
    txn(1, 1'b0, 1'b1, 32'h20, 2'b10, 32'd0, rd, er);
    chk("ld_word", rd, 32'h11223344);
    txn(1, 1'b0, 1'b1, 32'h22, 2'b01, 32'd0, rd, er);
    chk("ld_half", rd, 32'h00001122);
    txn(1, 1'b0, 1'b1, 32'h23, 2'b00, 32'd0, rd, er);
    chk("ld_byte", rd, 32'h00000011);
    txn(1, 1'b1, 1'b0, 32'h21, 2'b00, 32'h000000AB, rd, er);
    txn(1, 1'b1, 1'b0, 32'h22, 2'b01, 32'h0000CDEF, rd, er);
    txn(1, 1'b0, 1'b1, 32'h20, 2'b10, 32'd0, rd, er);
    chk("partial_merge", rd, 32'hCDEFAB44);

    txn(1, 1'b1, 1'b0, 32'h24, 2'b10, 32'h5A5A1234, rd, er);
    txn(1, 1'b1, 1'b0, 32'h26, 2'b10, 32'hFFFFFFFF, rd, er);
    chk("mis_word_store_err", {31'd0, er}, 32'd1);
    txn(1, 1'b0, 1'b1, 32'h21, 2'b01, 32'd0, rd, er);
    chk("mis_half_err", {31'd0, er}, 32'd1);
    chk("mis_half_data", rd, 32'd0);
    txn(1, 1'b0, 1'b1, 32'h24, 2'b11, 32'd0, rd, er);
    chk("size11_err", {31'd0, er}, 32'd1);
    txn(1, 1'b0, 1'b1, 32'h24, 2'b10, 32'd0, rd, er);
    chk("mis_no_write", rd, 32'h5A5A1234);
    txn(1, 1'b0, 1'b1, 32'h1000, 2'b10, 32'd0, rd, er);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_data", rd, 32'd0);
    txn(1, 1'b0, 1'b1, 32'hFFC, 2'b10, 32'd0, rd, er);
    chk("last_word_ok", {31'd0, er}, 32'd0);

    // Zero wait states, request held: even cycles accept, odd cycles are RESP and ignored.
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("b2b_ready_%0d", i), {31'd0, rdy[0]}, 32'(i % 2));
      cs = 3'b001; we_i = 1'b1; re_i = 1'b1; size_i = 2'b10;
      if (i % 2 == 0) begin
        addr_i = 32'h40; wdata_i = 32'(i);
      end else begin
        addr_i = 32'h44; wdata_i = 32'hBAD0_0000 | 32'(i);
      end
      @(negedge clk);
    end
    chk("b2b_ready_end", {31'd0, rdy[0]}, 32'd0);
    cs = 3'b000;
    chk("b2b_store_keeps_data", dm[0], dmod[0]);
    for (int k = 0; k < 4; k++) mref[0][32'h40 + k] = 8'(32'(18) >> (8 * k));
    txn(0, 1'b0, 1'b1, 32'h40, 2'b10, 32'd0, rd, er);
    chk("b2b_last_store", rd, 32'd18);
    txn(0, 1'b0, 1'b1, 32'h44, 2'b10, 32'd0, rd, er);
    chk("b2b_resp_ignored", rd, 32'd0);

    for (int n = 0; n < 150; n++) begin
      d  = $urandom_range(0, 2);
      r  = $urandom_range(0, 9);
      if (r == 0)      a = 32'h1000 + ($urandom & 32'h00FF_FFFF);
      else if (r == 1) a = 32'hFFC + 32'($urandom_range(0, 3));
      else             a = 32'($urandom_range(0, 127));
      sz = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      txn(d, op != 1, op != 0, a, sz, $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
